// File: rtl/key_debouncer.sv
// Pushbutton conditioner: synchronizes a bouncy raw key, accepts press/release
// after a stable debounce window, and flags a single long-hold event per press.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 5000,
    parameter int LONG_CYCLES     = 25000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       KEY_IN,
    output logic       key_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = ($clog2(LONG_CYCLES) > 26) ? $clog2(LONG_CYCLES) : 26;
    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(LONG_CYCLES - 1);
    localparam logic              IDLE_LEVEL = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t              state, state_next;
    logic                s1, s2, btn;
    logic [DB_W-1:0]     db_cnt, db_next;
    logic [HOLD_W-1:0]   hold_cnt, hold_next;
    logic                long_fired, fired_next;
    logic                level_next, press_next, release_next, long_next;
    logic [7:0]          count_next;

    // Raw key is only ever observed through s2.
    assign btn = s2 ^ IDLE_LEVEL;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1            <= IDLE_LEVEL;
            s2            <= IDLE_LEVEL;
            state         <= IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            long_fired    <= 1'b0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            s1            <= KEY_IN;
            s2            <= s1;
            state         <= state_next;
            db_cnt        <= db_next;
            hold_cnt      <= hold_next;
            long_fired    <= fired_next;
            key_level     <= level_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            long_pulse    <= long_next;
            press_count   <= count_next;
        end
    end

    always_comb begin
        state_next   = state;
        db_next      = db_cnt;
        hold_next    = hold_cnt;
        fired_next   = long_fired;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;
        count_next   = press_count;

        case (state)
            IDLE: begin
                if (btn) begin
                    state_next = PRESS_WAIT;
                    db_next    = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn) begin
                    state_next = IDLE;
                    db_next    = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_next = PRESSED;
                    press_next = 1'b1;
                    count_next = press_count + 8'd1;
                    hold_next  = '0;
                    fired_next = 1'b0;
                end else begin
                    db_next = db_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (btn) begin
                    // Hold counter saturates; the fired flag keeps the event single-shot.
                    if (hold_cnt != HOLD_LAST) begin
                        hold_next = hold_cnt + 1'b1;
                    end else if (!long_fired) begin
                        long_next  = 1'b1;
                        fired_next = 1'b1;
                    end
                end else begin
                    state_next = RELEASE_WAIT;
                    db_next    = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn) begin
                    state_next = PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                    hold_next    = '0;
                    fired_next   = 1'b0;
                    db_next      = '0;
                end else begin
                    db_next = db_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, active-low key.
module tb_key_debouncer;

    logic       CLOCK_50;
    logic       reset;
    logic       KEY_IN;
    logic       key_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_press, n_release, n_long, excl_viol;
    int last_press, last_release, last_long;

    key_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .ACTIVE_LOW     (1)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .KEY_IN       (KEY_IN),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .press_count  (press_count)
    );

    // clock / reset
    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // driver tasks
    task automatic clear_stats();
        n_press = 0; n_release = 0; n_long = 0; excl_viol = 0;
        last_press = -1; last_release = -1; last_long = -1;
    endtask

    // Advance n rising edges; observe outputs 1 time unit after each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            #1;
            cyc++;
            if (press_pulse)   begin n_press++;   last_press   = cyc; end
            if (release_pulse) begin n_release++; last_release = cyc; end
            if (long_pulse)    begin n_long++;    last_long    = cyc; end
            if ((int'(press_pulse) + int'(release_pulse) + int'(long_pulse)) > 1) excl_viol++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; KEY_IN = 1'b1;
        step(3);
        reset = 1'b0;
        checks++; if (key_level !== 1'b0) begin failures++; $display("FAIL reset_level got=%b exp=0", key_level); end
        checks++; if ({press_pulse, release_pulse, long_pulse} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {press_pulse, release_pulse, long_pulse}); end
        checks++; if (press_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", press_count); end
        step(3);
        checks++; if (key_level !== 1'b0) begin failures++; $display("FAIL idle_level got=%b exp=0", key_level); end
    endtask

    task automatic test_clean_press();
        clear_stats();
        KEY_IN = 1'b0;
        step(6);
        checks++; if (n_press !== 0 || key_level !== 1'b0) begin failures++; $display("FAIL press_early presses=%0d level=%b exp=0/0", n_press, key_level); end
        step(1);
        checks++; if (press_pulse !== 1'b1) begin failures++; $display("FAIL press_edge7 got=%b exp=1", press_pulse); end
        checks++; if (key_level !== 1'b1) begin failures++; $display("FAIL press_level got=%b exp=1", key_level); end
        checks++; if (press_count !== 8'd1) begin failures++; $display("FAIL press_count got=%0d exp=1", press_count); end
        step(1);
        checks++; if (press_pulse !== 1'b0) begin failures++; $display("FAIL press_width got=%b exp=0", press_pulse); end
        KEY_IN = 1'b1;
        step(6);
        checks++; if (n_release !== 0 || key_level !== 1'b1) begin failures++; $display("FAIL release_early releases=%0d level=%b exp=0/1", n_release, key_level); end
        step(1);
        checks++; if (release_pulse !== 1'b1) begin failures++; $display("FAIL release_edge7 got=%b exp=1", release_pulse); end
        checks++; if (key_level !== 1'b0) begin failures++; $display("FAIL release_level got=%b exp=0", key_level); end
        step(1);
        checks++; if (release_pulse !== 1'b0) begin failures++; $display("FAIL release_width got=%b exp=0", release_pulse); end
    endtask

    task automatic test_glitch();
        clear_stats();
        KEY_IN = 1'b0;
        step(3);
        KEY_IN = 1'b1;
        step(20);
        checks++; if (n_press !== 0 || n_release !== 0) begin failures++; $display("FAIL glitch_pulses press=%0d release=%0d exp=0/0", n_press, n_release); end
        checks++; if (key_level !== 1'b0) begin failures++; $display("FAIL glitch_level got=%b exp=0", key_level); end
        checks++; if (press_count !== 8'd1) begin failures++; $display("FAIL glitch_count got=%0d exp=1", press_count); end
    endtask

    task automatic test_release_bounce();
        int t0;
        clear_stats();
        KEY_IN = 1'b0;
        step(10);
        for (int b = 0; b < 2; b++) begin
            KEY_IN = 1'b1; step(2);
            KEY_IN = 1'b0; step(2);
        end
        KEY_IN = 1'b1;
        t0 = cyc;
        step(20);
        checks++; if (n_release !== 1) begin failures++; $display("FAIL bounce_releases got=%0d exp=1", n_release); end
        checks++; if (last_release !== t0 + 7) begin failures++; $display("FAIL bounce_latency got=%0d exp=%0d", last_release - t0, 7); end
        checks++; if (n_press !== 1 || n_long !== 0) begin failures++; $display("FAIL bounce_extra press=%0d long=%0d exp=1/0", n_press, n_long); end
        checks++; if (press_count !== 8'd2) begin failures++; $display("FAIL bounce_count got=%0d exp=2", press_count); end
    endtask

    task automatic test_long_hold();
        clear_stats();
        KEY_IN = 1'b0;
        step(40);
        checks++; if (n_press !== 1) begin failures++; $display("FAIL long_presses got=%0d exp=1", n_press); end
        checks++; if (n_long !== 1) begin failures++; $display("FAIL long_count got=%0d exp=1", n_long); end
        checks++; if (last_long !== last_press + 20) begin failures++; $display("FAIL long_delay got=%0d exp=20", last_long - last_press); end
        KEY_IN = 1'b1;
        step(12);
        checks++; if (n_release !== 1 || n_long !== 1) begin failures++; $display("FAIL long_release release=%0d long=%0d exp=1/1", n_release, n_long); end
        checks++; if (excl_viol !== 0) begin failures++; $display("FAIL pulse_exclusive got=%0d exp=0", excl_viol); end
        // A second hold must fire its own long event.
        clear_stats();
        KEY_IN = 1'b0; step(30);
        KEY_IN = 1'b1; step(10);
        checks++; if (n_long !== 1 || last_long !== last_press + 20) begin failures++; $display("FAIL long_rearm long=%0d delay=%0d exp=1/20", n_long, last_long - last_press); end
    endtask

    task automatic test_wrap();
        clear_stats();
        reset = 1'b1; step(2); reset = 1'b0;
        for (int p = 0; p < 255; p++) begin
            KEY_IN = 1'b0; step(8);
            KEY_IN = 1'b1; step(8);
        end
        checks++; if (press_count !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", press_count); end
        KEY_IN = 1'b0; step(8);
        KEY_IN = 1'b1; step(8);
        checks++; if (press_count !== 8'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", press_count); end
        checks++; if (n_press !== 256) begin failures++; $display("FAIL wrap_presses got=%0d exp=256", n_press); end
    endtask

    task automatic test_reset_mid_hold();
        KEY_IN = 1'b0;
        step(12);
        checks++; if (key_level !== 1'b1) begin failures++; $display("FAIL midhold_pressed got=%b exp=1", key_level); end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++; if ({key_level, press_pulse, release_pulse, long_pulse} !== 4'b0000 || press_count !== 8'd0) begin
            failures++; $display("FAIL midhold_reset outs=%b count=%0d exp=0000/0", {key_level, press_pulse, release_pulse, long_pulse}, press_count);
        end
        clear_stats();
        step(6);
        checks++; if (n_press !== 0) begin failures++; $display("FAIL midhold_early got=%0d exp=0", n_press); end
        step(1);
        checks++; if (press_pulse !== 1'b1 || press_count !== 8'd1) begin failures++; $display("FAIL midhold_repress pulse=%b count=%0d exp=1/1", press_pulse, press_count); end
        KEY_IN = 1'b1;
        step(10);
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_clean_press();
        test_glitch();
        test_release_bounce();
        test_long_hold();
        test_wrap();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
